mod_updown_counter: RTL and testbench

Parametrised modulo-MOD up/down counter, the general successor to the fixed down-counter used for bit and byte sequencing in the SPI slave and RAM control path. It adds a runtime direction select, synchronous clear and parallel load, and a selectable wrap or saturate policy at the modulus boundary. It also provides terminal-count and wrap-event outputs so that controllers can sequence frames without external compare logic.

---
 rtl/mod_updown_counter.sv | 83 ++++++++
 tb/tb_mod_updown_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-MOD up/down counter with load, clear, and a wrap-or-saturate boundary policy.
// Ports: clk, rst (async, active-high), clr, load/load_val, enable, up -> count, tc, wrap_p, sat, wrap_cnt.
// count, wrap_p, sat and wrap_cnt are registered; tc is combinational from count and up.
module mod_updown_counter #(
    parameter int MOD          = 8,
    parameter int COUNTER_BITS = 3,
    parameter bit WRAP         = 1'b1,
    parameter int RESET_VAL    = MOD - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    load,
    input  logic [COUNTER_BITS-1:0] load_val,
    input  logic                    enable,
    input  logic                    up,
    output logic [COUNTER_BITS-1:0] count,
    output logic                    tc,
    output logic                    wrap_p,
    output logic                    sat,
    output logic [COUNTER_BITS-1:0] wrap_cnt
);

    // Boundary and reset constants at counter width. MOD itself may not fit
    // in COUNTER_BITS (MOD == 2**COUNTER_BITS), so only MOD-1 is ever formed.
    localparam logic [COUNTER_BITS-1:0] MAX_V = COUNTER_BITS'(MOD - 1);
    localparam logic [COUNTER_BITS-1:0] RST_V = COUNTER_BITS'(RESET_VAL);
    localparam logic [COUNTER_BITS-1:0] ONE   = COUNTER_BITS'(1);

    logic [COUNTER_BITS-1:0] load_clamped;

    // Out-of-range load values land on the top legal value.
    always_comb begin
        load_clamped = load_val;
        if (int'(load_val) > MOD - 1) begin
            load_clamped = MAX_V;
        end
    end

    // Terminal count depends on the direction being sampled this cycle, so a
    // direction change moves tc immediately and the next edge acts on it.
    assign tc = up ? (count == MAX_V) : (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= RST_V;
            wrap_p   <= 1'b0;
            sat      <= 1'b0;
            wrap_cnt <= '0;
        end else if (clr) begin
            count    <= RST_V;
            wrap_p   <= 1'b0;
            sat      <= 1'b0;
            wrap_cnt <= '0;
        end else if (load) begin
            // load takes the cycle: no count step even if enable is high
            count  <= load_clamped;
            wrap_p <= 1'b0;
            sat    <= 1'b0;
        end else if (enable) begin
            if (!tc) begin
                // Interior step; when saturated this is the move away from
                // the boundary that releases sat.
                count  <= up ? (count + ONE) : (count - ONE);
                wrap_p <= 1'b0;
                sat    <= 1'b0;
            end else if (WRAP) begin
                count    <= up ? '0 : MAX_V;
                wrap_p   <= 1'b1;
                sat      <= 1'b0;
                wrap_cnt <= wrap_cnt + ONE;
            end else begin
                // Saturating policy: pinned at the boundary.
                wrap_p <= 1'b0;
                sat    <= 1'b1;
            end
        end else begin
            // Hold: count and sat keep their values, the wrap pulse drops.
            wrap_p <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed testbench for mod_updown_counter across four parameterisations.
// Inputs are shared; each scenario checks only the instance it targets.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       load;
    logic [2:0] load_val;
    logic       enable;
    logic       up;

    // a: MOD=8 wrap (defaults), s: MOD=8 saturate, m6: MOD=6 wrap, m2: MOD=2 wrap
    logic [2:0] count_a, wcnt_a, count_s, wcnt_s, count_6, wcnt_6, count_2, wcnt_2;
    logic       tc_a, wrap_a, sat_a, tc_s, wrap_s, sat_s;
    logic       tc_6, wrap_6, sat_6, tc_2, wrap_2, sat_2;

    int checks = 0;
    int errors = 0;

    mod_updown_counter u_a (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .enable(enable), .up(up), .count(count_a), .tc(tc_a), .wrap_p(wrap_a),
        .sat(sat_a), .wrap_cnt(wcnt_a)
    );

    mod_updown_counter #(.MOD(8), .COUNTER_BITS(3), .WRAP(1'b0)) u_s (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .enable(enable), .up(up), .count(count_s), .tc(tc_s), .wrap_p(wrap_s),
        .sat(sat_s), .wrap_cnt(wcnt_s)
    );

    mod_updown_counter #(.MOD(6), .COUNTER_BITS(3), .WRAP(1'b1)) u_m6 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .enable(enable), .up(up), .count(count_6), .tc(tc_6), .wrap_p(wrap_6),
        .sat(sat_6), .wrap_cnt(wcnt_6)
    );

    mod_updown_counter #(.MOD(2), .COUNTER_BITS(3), .WRAP(1'b1)) u_m2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .enable(enable), .up(up), .count(count_2), .tc(tc_2), .wrap_p(wrap_2),
        .sat(sat_2), .wrap_cnt(wcnt_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = 3'd0; enable = 1'b0; up = 1'b0;
        #1;
        checks++; if (count_a !== 3'd7) begin errors++; $display("FAIL reset_count: got %0d expected 7", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL reset_wrap_p: got %0b expected 0", wrap_a); end
        checks++; if (sat_a !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", sat_a); end
        checks++; if (wcnt_a !== 3'd0) begin errors++; $display("FAIL reset_wrap_cnt: got %0d expected 0", wcnt_a); end
        checks++; if (tc_a !== 1'b0) begin errors++; $display("FAIL reset_tc_down: got %0b expected 0", tc_a); end
        checks++; if (count_6 !== 3'd5) begin errors++; $display("FAIL reset_count_m6: got %0d expected 5", count_6); end
        checks++; if (count_2 !== 3'd1) begin errors++; $display("FAIL reset_count_m2: got %0d expected 1", count_2); end
        up = 1'b1;
        #1;
        checks++; if (tc_a !== 1'b1) begin errors++; $display("FAIL reset_tc_up: got %0b expected 1", tc_a); end
        @(negedge clk);
        rst = 1'b0;
        up = 1'b0;
        tick;
        checks++; if (count_a !== 3'd7) begin errors++; $display("FAIL hold_after_reset: got %0d expected 7", count_a); end
    endtask

    task automatic test_down_wrap;
        int exp_c;
        enable = 1'b1; up = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick;
            exp_c = (15 - k) % 8;
            checks++; if (count_a !== exp_c[2:0]) begin errors++; $display("FAIL down_count[%0d]: got %0d expected %0d", k, count_a, exp_c); end
            checks++; if (wrap_a !== (k == 8)) begin errors++; $display("FAIL down_wrap_p[%0d]: got %0b expected %0b", k, wrap_a, (k == 8)); end
        end
        checks++; if (wcnt_a !== 3'd1) begin errors++; $display("FAIL down_wrap_cnt: got %0d expected 1", wcnt_a); end
        tick;
        checks++; if (count_a !== 3'd6) begin errors++; $display("FAIL down_after_wrap: got %0d expected 6", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL down_pulse_width: got %0b expected 0", wrap_a); end
        enable = 1'b0;
    endtask

    task automatic test_up_wrap;
        load = 1'b1; load_val = 3'd6;
        tick;
        load = 1'b0;
        checks++; if (count_a !== 3'd6) begin errors++; $display("FAIL up_load6: got %0d expected 6", count_a); end
        checks++; if (wcnt_a !== 3'd1) begin errors++; $display("FAIL up_load_keeps_wcnt: got %0d expected 1", wcnt_a); end
        enable = 1'b1; up = 1'b1;
        tick;
        checks++; if (count_a !== 3'd7) begin errors++; $display("FAIL up_to7: got %0d expected 7", count_a); end
        checks++; if (tc_a !== 1'b1) begin errors++; $display("FAIL up_tc_at7: got %0b expected 1", tc_a); end
        tick;
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL up_wrap_to0: got %0d expected 0", count_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL up_wrap_p: got %0b expected 1", wrap_a); end
        checks++; if (wcnt_a !== 3'd2) begin errors++; $display("FAIL up_wrap_cnt: got %0d expected 2", wcnt_a); end
        tick;
        checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL up_to1: got %0d expected 1", count_a); end
        up = 1'b0;
        tick;
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL dirchg_count: got %0d expected 0", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL dirchg_wrap_p: got %0b expected 0", wrap_a); end
        checks++; if (tc_a !== 1'b1) begin errors++; $display("FAIL dirchg_tc: got %0b expected 1", tc_a); end
        enable = 1'b0;
    endtask

    task automatic test_priority;
        load = 1'b1; clr = 1'b1; enable = 1'b1; load_val = 3'd2;
        tick;
        clr = 1'b0;
        checks++; if (count_a !== 3'd7) begin errors++; $display("FAIL prio_clr_count: got %0d expected 7", count_a); end
        checks++; if (wcnt_a !== 3'd0) begin errors++; $display("FAIL prio_clr_wcnt: got %0d expected 0", wcnt_a); end
        load_val = 3'd3; up = 1'b1;
        tick;
        checks++; if (count_a !== 3'd3) begin errors++; $display("FAIL prio_load_over_en: got %0d expected 3", count_a); end
        load = 1'b0; enable = 1'b0;
    endtask

    task automatic test_load_clamp;
        logic [2:0] vals [4];
        logic [2:0] exps [4];
        vals = '{3'd7, 3'd6, 3'd4, 3'd0};
        exps = '{3'd5, 3'd5, 3'd4, 3'd0};
        load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            load_val = vals[i];
            tick;
            checks++; if (count_6 !== exps[i]) begin errors++; $display("FAIL clamp_m6[%0d]: got %0d expected %0d", vals[i], count_6, exps[i]); end
        end
        load = 1'b0;
    endtask

    task automatic test_saturate;
        logic [2:0] exp_c [4];
        logic       exp_s [4];
        exp_c = '{3'd6, 3'd7, 3'd7, 3'd7};
        exp_s = '{1'b0, 1'b0, 1'b1, 1'b1};
        clr = 1'b1;
        tick;
        clr = 1'b0;
        load = 1'b1; load_val = 3'd5;
        tick;
        load = 1'b0;
        checks++; if (count_s !== 3'd5) begin errors++; $display("FAIL sat_load5: got %0d expected 5", count_s); end
        enable = 1'b1; up = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (count_s !== exp_c[i]) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, count_s, exp_c[i]); end
            checks++; if (sat_s !== exp_s[i]) begin errors++; $display("FAIL sat_flag[%0d]: got %0b expected %0b", i, sat_s, exp_s[i]); end
            checks++; if (wrap_s !== 1'b0) begin errors++; $display("FAIL sat_wrap_p[%0d]: got %0b expected 0", i, wrap_s); end
        end
        checks++; if (wcnt_s !== 3'd0) begin errors++; $display("FAIL sat_wcnt: got %0d expected 0", wcnt_s); end
        enable = 1'b0;
        tick;
        checks++; if (sat_s !== 1'b1) begin errors++; $display("FAIL sat_hold: got %0b expected 1", sat_s); end
        enable = 1'b1; up = 1'b0;
        tick;
        checks++; if (count_s !== 3'd6) begin errors++; $display("FAIL sat_release_count: got %0d expected 6", count_s); end
        checks++; if (sat_s !== 1'b0) begin errors++; $display("FAIL sat_release_flag: got %0b expected 0", sat_s); end
        enable = 1'b0;
    endtask

    task automatic test_async_reset;
        load = 1'b1; load_val = 3'd3;
        tick;
        load = 1'b0;
        checks++; if (count_a !== 3'd3) begin errors++; $display("FAIL arst_pre: got %0d expected 3", count_a); end
        enable = 1'b1; up = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (count_a !== 3'd7) begin errors++; $display("FAIL arst_count: got %0d expected 7", count_a); end
        checks++; if (wrap_a !== 1'b0) begin errors++; $display("FAIL arst_wrap_p: got %0b expected 0", wrap_a); end
        #1;
        rst = 1'b0;
        #3;
        checks++; if (count_a !== 3'd7) begin errors++; $display("FAIL arst_no_edge: got %0d expected 7", count_a); end
        tick;
        checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL arst_resume: got %0d expected 0", count_a); end
        checks++; if (wrap_a !== 1'b1) begin errors++; $display("FAIL arst_resume_wrap: got %0b expected 1", wrap_a); end
        enable = 1'b0;
    endtask

    task automatic test_full_range;
        int pulses;
        pulses = 0;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        load = 1'b1; load_val = 3'd0;
        tick;
        load = 1'b0;
        enable = 1'b1; up = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            checks++; if (count_a !== 3'(k % 8)) begin errors++; $display("FAIL full_count[%0d]: got %0d expected %0d", k, count_a, k % 8); end
            checks++; if (wrap_a !== (k % 8 == 0)) begin errors++; $display("FAIL full_wrap_p[%0d]: got %0b expected %0b", k, wrap_a, (k % 8 == 0)); end
            if (wrap_a === 1'b1) pulses++;
        end
        checks++; if (wcnt_a !== 3'd2) begin errors++; $display("FAIL full_wcnt: got %0d expected 2", wcnt_a); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL full_pulses: got %0d expected 2", pulses); end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        enable = 1'b1;
        // Alternating direction keeps tc high every cycle, so every edge wraps.
        for (int k = 0; k < 3; k++) begin
            up = (k % 2 == 0);
            tick;
            checks++; if (count_2 !== ((k % 2 == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d", k, count_2); end
            checks++; if (wrap_2 !== 1'b1) begin errors++; $display("FAIL b2b_wrap_p[%0d]: got %0b expected 1", k, wrap_2); end
            checks++; if (wcnt_2 !== 3'(k + 1)) begin errors++; $display("FAIL b2b_wcnt[%0d]: got %0d expected %0d", k, wcnt_2, k + 1); end
        end
        enable = 1'b0;
        tick;
        checks++; if (wrap_2 !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %0b expected 0", wrap_2); end
    endtask

    initial begin
        test_reset;
        test_down_wrap;
        test_up_wrap;
        test_priority;
        test_load_clamp;
        test_saturate;
        test_async_reset;
        test_full_range;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
